// File: rtl/hb1_interp.sv
// hb1_interp: 2x half-band interpolator.
// A 4-tap line shifts on each input strobe. Every input sample produces two
// output samples. Phase A is the filtered in-between value and appears two
// cycles after the strobe. Phase B is the centre tap and appears H cycles
// after phase A. H is half the measured input interval.
module hb1_interp #(
   parameter int PW       = 16,
   parameter int DEF_HALF = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clk_vld_in,
   input  logic signed [34:0] dat_in,
   output logic               clk_vld_out,
   output logic signed [34:0] dat_out,
   output logic               ovr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PH_A   = 2'd1,
      WAIT_B = 2'd2
   } state_t;

   localparam logic signed [67:0] C_OUT   = 68'sd54357298;
   localparam logic signed [67:0] C_IN    = 68'sd316817548;
   localparam logic signed [67:0] A_MAX   = 68'sd17179869183;
   localparam logic signed [67:0] A_MIN   = -68'sd17179869184;
   localparam logic [PW-1:0]      CNT_MAX = {PW{1'b1}};

   logic signed [34:0] x0, x1, x2, x3;
   logic [PW-1:0]      icnt;
   logic [PW-1:0]      per;
   logic [1:0]         seen;
   logic [PW-1:0]      h_raw;
   logic [PW-1:0]      h;
   logic [PW-1:0]      wcnt;
   state_t             state;

   logic signed [35:0] s0, s1;
   logic signed [67:0] acc;
   logic signed [67:0] a_full;
   logic signed [34:0] a_sat;

   // Tap line: advances only when a new input sample is strobed in.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x0 <= 35'sd0;
         x1 <= 35'sd0;
         x2 <= 35'sd0;
         x3 <= 35'sd0;
      end else if (clk_vld_in) begin
         x0 <= dat_in;
         x1 <= x0;
         x2 <= x1;
         x3 <= x2;
      end else begin
         x0 <= x0;
         x1 <= x1;
         x2 <= x2;
         x3 <= x3;
      end
   end

   // Input interval measurement: the counter value at a strobe is the distance from the previous strobe.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         icnt <= {PW{1'b0}};
         per  <= {PW{1'b0}};
         seen <= 2'd0;
      end else if (clk_vld_in) begin
         icnt <= {{(PW-1){1'b0}}, 1'b1};
         per  <= icnt;
         if (seen != 2'd2) begin
            seen <= seen + 2'd1;
         end else begin
            seen <= seen;
         end
      end else if (icnt != CNT_MAX) begin
         icnt <= icnt + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         icnt <= icnt;
      end
   end

   // Phase-B delay: half the measured interval once it is known. Never less than one cycle.
   always_comb begin
      h_raw = PW'(DEF_HALF);
      h     = {{(PW-1){1'b0}}, 1'b1};
      if (seen == 2'd2) begin
         h_raw = per >> 1'b1;
      end else begin
         h_raw = PW'(DEF_HALF);
      end
      if (h_raw == {PW{1'b0}}) begin
         h = {{(PW-1){1'b0}}, 1'b1};
      end else begin
         h = h_raw;
      end
   end

   // Phase A: symmetric 4-tap half-band sum. The shift by 29 applies the 2x gain. The result saturates to 35 bits.
   always_comb begin
      s0     = 36'(x0) + 36'(x3);
      s1     = 36'(x1) + 36'(x2);
      acc    = (68'(s1) * C_IN) - (68'(s0) * C_OUT);
      a_full = acc >>> 7'd29;
      a_sat  = a_full[34:0];
      if (a_full > A_MAX) begin
         a_sat = A_MAX[34:0];
      end else if (a_full < A_MIN) begin
         a_sat = A_MIN[34:0];
      end else begin
         a_sat = a_full[34:0];
      end
   end

   // Output sequencer: emit A, wait H cycles, emit B. A strobe arriving early drops the pending B.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         wcnt        <= {PW{1'b0}};
         dat_out     <= 35'sd0;
         clk_vld_out <= 1'b0;
         ovr         <= 1'b0;
      end else begin
         clk_vld_out <= 1'b0;
         case (state)
            IDLE: begin
               if (clk_vld_in) begin
                  state <= PH_A;
               end else begin
                  state <= IDLE;
               end
            end
            PH_A: begin
               dat_out     <= a_sat;
               clk_vld_out <= 1'b1;
               wcnt        <= h - {{(PW-1){1'b0}}, 1'b1};
               if (clk_vld_in) begin
                  ovr   <= 1'b1;
                  state <= PH_A;
               end else begin
                  state <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (clk_vld_in) begin
                  ovr   <= 1'b1;
                  state <= PH_A;
               end else if (wcnt == {PW{1'b0}}) begin
                  dat_out     <= x1;
                  clk_vld_out <= 1'b1;
                  state       <= IDLE;
               end else begin
                  wcnt <= wcnt - {{(PW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hb1_interp.sv
// Testbench for hb1_interp. A schedule-based reference model predicts every
// output pulse from the filter equations and the interval rules. The DUT
// outputs are compared every cycle. Directed scenarios check the exact values
// and timings that are known in advance.
module tb_hb1_interp;
   localparam int PW       = 16;
   localparam int DEF_HALF = 2;
   localparam logic signed [34:0] M    = 35'sd17179869183;
   localparam logic signed [34:0] MINV = -35'sd17179869184;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               clk_vld_in = 1'b0;
   logic signed [34:0] dat_in = 35'sd0;
   logic               clk_vld_out;
   logic signed [34:0] dat_out;
   logic               ovr;

   hb1_interp #(.PW(PW), .DEF_HALF(DEF_HALF)) dut (
      .clk(clk), .rstn(rstn), .clk_vld_in(clk_vld_in), .dat_in(dat_in),
      .clk_vld_out(clk_vld_out), .dat_out(dat_out), .ovr(ovr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                 t;
      logic signed [34:0] v;
      bit                 is_b;
   } ev_t;

   int                 checks = 0;
   int                 failures = 0;
   int                 cyc = 0;
   ev_t                evq[$];
   logic signed [34:0] tap[4];
   logic signed [34:0] exp_dat;
   bit                 exp_ovr;
   int                 n_str;
   int                 last_t;
   int                 obs_t[$];
   logic signed [34:0] obs_v[$];
   int                 imp_exp[10] = '{-106167, 0, 618784, 1048576, 618784, 0, -106167, 0, 0, 0};

   task automatic check(input string tag, input logic signed [63:0] o, input logic signed [63:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   function automatic logic signed [34:0] ref_a(input logic signed [34:0] a, b, c, d);
      logic signed [95:0] s_out, s_in, acc, q;
      s_out = 96'(a) + 96'(d);
      s_in  = 96'(b) + 96'(c);
      acc   = s_in * 96'sd316817548 - s_out * 96'sd54357298;
      q     = acc >>> 29;
      if (q > 96'sd17179869183) q = 96'sd17179869183;
      if (q < -96'sd17179869184) q = -96'sd17179869184;
      return q[34:0];
   endfunction

   function automatic logic signed [34:0] rnd35();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom % 8)
         0: return M;
         1: return MINV;
         default: return r[34:0];
      endcase
   endfunction

   task automatic model_reset();
      evq.delete();
      for (int i = 0; i < 4; i++) tap[i] = 35'sd0;
      exp_dat = 35'sd0;
      exp_ovr = 1'b0;
      n_str   = 0;
      last_t  = 0;
   endtask

   task automatic model_strobe(input logic signed [34:0] d);
      int  p, h, nb;
      ev_t e;
      nb = 0;
      foreach (evq[i]) if (evq[i].is_b) nb++;
      if (nb != 0) begin
         evq = evq.find(x) with (!x.is_b);
         exp_ovr = 1'b1;
      end
      tap[3] = tap[2]; tap[2] = tap[1]; tap[1] = tap[0]; tap[0] = d;
      p = cyc - last_t;
      if (p > (1 << PW) - 1) p = (1 << PW) - 1;
      n_str++;
      last_t = cyc;
      h = (n_str >= 2) ? p / 2 : DEF_HALF;
      if (h == 0) h = 1;
      e.t = cyc + 2;     e.v = ref_a(tap[0], tap[1], tap[2], tap[3]); e.is_b = 1'b0; evq.push_back(e);
      e.t = cyc + 2 + h; e.v = tap[1];                                e.is_b = 1'b1; evq.push_back(e);
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model.
   task automatic step(input bit r, input bit v, input logic signed [34:0] d);
      bit exp_vld;
      rstn = r; clk_vld_in = v; dat_in = d;
      if (!r) model_reset();
      @(negedge clk);
      exp_vld = 1'b0;
      foreach (evq[i]) if (evq[i].t == cyc) begin exp_vld = 1'b1; exp_dat = evq[i].v; end
      evq = evq.find(x) with (x.t > cyc);
      check("clk_vld_out", {63'd0, clk_vld_out}, {63'd0, exp_vld});
      check("dat_out", dat_out, exp_dat);
      check("ovr", {63'd0, ovr}, {63'd0, exp_ovr});
      if (clk_vld_out === 1'b1) begin obs_t.push_back(cyc); obs_v.push_back(dat_out); end
      if (v && r) model_strobe(d);
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, rnd35());
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom % 2), rnd35());
      obs_t.delete(); obs_v.delete();
   endtask

   initial begin
      int t0, t1, t2, hits;

      // Reset with random activity on the inputs
      do_reset(6);
      idle(3);

      // Impulse at spacing 8
      step(1'b1, 1'b1, 35'sd1048576); idle(7);
      for (int k = 0; k < 4; k++) begin step(1'b1, 1'b1, 35'sd0); idle(7); end
      idle(4);
      check("impulse_count", obs_v.size(), 10);
      for (int i = 0; i < 10 && i < obs_v.size(); i++) check("impulse_val", obs_v[i], imp_exp[i]);

      // Timing at spacing 10: DEF_HALF first, then measured half-interval
      do_reset(2);
      t0 = cyc;
      step(1'b1, 1'b1, rnd35()); idle(9);
      step(1'b1, 1'b1, rnd35()); idle(12);
      check("timing_count", obs_t.size(), 4);
      if (obs_t.size() >= 4) begin
         check("timing_a1", obs_t[0] - t0, 2);
         check("timing_b1", obs_t[1] - t0, 4);
         check("timing_a2", obs_t[2] - t0, 12);
         check("timing_b2", obs_t[3] - t0, 17);
      end

      // Saturation of phase A
      do_reset(2);
      step(1'b1, 1'b1, M);  idle(7);
      step(1'b1, 1'b1, -M); idle(7);
      step(1'b1, 1'b1, -M); idle(7);
      step(1'b1, 1'b1, M);  idle(10);
      check("sat_count", obs_v.size(), 8);
      if (obs_v.size() >= 8) begin
         check("sat_a4", obs_v[6], MINV);
         check("sat_b4", obs_v[7], -M);
      end
      check("sat_ovr", {63'd0, ovr}, 64'sd0);

      // Overrun: B of the second sample is dropped and ovr sticks
      do_reset(2);
      step(1'b1, 1'b1, rnd35()); idle(19);
      t1 = cyc;
      step(1'b1, 1'b1, rnd35()); idle(5);
      t2 = cyc;
      step(1'b1, 1'b1, rnd35()); idle(12);
      hits = 0;
      foreach (obs_t[i]) if (obs_t[i] == t1 + 12) hits++;
      check("ovr_b_dropped", hits, 0);
      hits = 0;
      foreach (obs_t[i]) if (obs_t[i] == t2 + 2) hits++;
      check("ovr_new_a", hits, 1);
      idle(5);
      check("ovr_sticky", {63'd0, ovr}, 64'sd1);

      // Mid-operation reset during WAIT_B
      do_reset(2);
      step(1'b1, 1'b1, rnd35());
      step(1'b1, 1'b0, 35'sd0);
      step(1'b1, 1'b0, 35'sd0);
      step(1'b0, 1'b0, 35'sd0);
      obs_t.delete(); obs_v.delete();
      idle(6);
      check("midrst_no_pulse", obs_t.size(), 0);
      t0 = cyc;
      step(1'b1, 1'b1, rnd35()); idle(8);
      check("midrst_count", obs_t.size(), 2);
      if (obs_t.size() >= 2) begin
         check("midrst_a", obs_t[0] - t0, 2);
         check("midrst_b", obs_t[1] - t0, 2 + DEF_HALF);
      end

      // Randomized spacing and data, including overruns
      do_reset(2);
      for (int k = 0; k < 150; k++) begin
         step(1'b1, 1'b1, rnd35());
         idle($urandom_range(1, 13));
      end
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/hb1_interp.md
HB1_INTERP -- requirements
Module: hb1_interp

Interface
REQ-001 SHALL have parameter PW, default 16: width of the input-interval counter.
REQ-002 SHALL have parameter DEF_HALF, default 2: phase-B delay used until an input interval has been measured.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clk_vld_in, input, 1: input sample strobe, one cycle high per sample.
REQ-006 SHALL have port dat_in, input, 35, signed: input sample, sampled when clk_vld_in=1.
REQ-007 SHALL have port clk_vld_out, output, 1: output sample strobe, two pulses per input sample.
REQ-008 SHALL have port dat_out, output, 35, signed: output sample, held between strobes.
REQ-009 SHALL have port ovr, output, 1: sticky overrun flag.

Function
REQ-010 SHALL be a 2x half-band interpolator, the inverse-direction counterpart of the team's 2x half-band decimator.
REQ-011 SHALL keep a 4-deep tap line x0..x3 that shifts only on clk_vld_in (x0<=dat_in, x1<=x0, x2<=x1, x3<=x2).
REQ-012 SHALL compute phase A from the updated taps: s0=x0+x3 and s1=x1+x2, each 36-bit signed.
- acc = -54357298*s0 + 316817548*s1, in a signed accumulator at least 66 bits wide.
- A = acc >>> 29: arithmetic shift, floor rounding, gain of 2 included.
REQ-013 SHALL compute phase B as x1 (centre tap with x2 gain, exact, no rounding).
REQ-014 SHALL saturate phase A to [-2^34, 2^34-1] before output; phase B never saturates.
REQ-015 SHALL, for a strobe in cycle t, assert clk_vld_out in cycle t+2 with dat_out=A.
REQ-016 SHALL assert clk_vld_out in cycle t+2+H with dat_out=B, where H=P>>1.
REQ-017 SHALL define P as the cycle distance between the two most recent strobes, counted by a PW-bit counter saturating at 2^PW-1.
REQ-018 SHALL use H=DEF_HALF until two strobes have been seen since reset; H=0 is forced to 1.
REQ-019 SHALL implement a state machine with exactly these states and transitions:
- IDLE -> PH_A on a strobe.
- PH_A (1 cycle, A registered) -> WAIT_B.
- WAIT_B counts down H-1 cycles, then registers B -> IDLE.
REQ-020 SHALL keep clk_vld_out a single-cycle pulse; dat_out holds its last value otherwise.
REQ-021 SHALL handle a strobe arriving while in PH_A or WAIT_B as follows:
- The pending B is dropped.
- ovr is set to 1.
- The FSM restarts at PH_A for the new sample.
- The taps shift normally.
REQ-022 SHALL set ovr only per REQ-021, and clear ovr only by reset.
REQ-023 SHALL treat a strobe in the same cycle as the final WAIT_B cycle as an overrun (drop B, set ovr).
REQ-024 SHALL require a minimum input spacing of P>=4 for lossless operation; shorter spacing is handled per REQ-021.

Reset
REQ-025 SHALL, on rstn=0, immediately clear all of the following:
- x0..x3 = 0
- dat_out = 0
- clk_vld_out = 0
- ovr = 0
- FSM = IDLE
- interval counter and seen-count = 0, so H returns to DEF_HALF
REQ-026 SHALL abandon any pending phase-A or phase-B output when reset occurs mid-operation, with no clk_vld_out pulse after rstn rises until a new strobe.

Verification
REQ-027 Reset: hold rstn=0 with random dat_in and clk_vld_in -> dat_out=0, clk_vld_out=0, ovr=0 throughout.
REQ-028 Impulse at spacing 8: dat_in=2^20 on the first strobe, 0 on later strobes -> (A,B) pairs (-106167,0), (618784,1048576), (618784,0), (-106167,0), then (0,0).
REQ-029 Timing at spacing 10: first strobe at cycle t -> pulses at t+2 and t+4 (DEF_HALF); second strobe at t+10 -> pulses at t+12 and t+17.
REQ-030 Saturation, M=2^34-1: inputs M,-M,-M,M at spacing 8 -> phase A of the 4th sample = -2^34, phase B = -M, ovr=0.
REQ-031 Overrun: spacing 20, then a strobe 6 cycles later -> B of the earlier sample is never pulsed, ovr=1 and stays 1, and A of the new sample is pulsed 2 cycles after its strobe.
REQ-032 Mid-operation reset: rstn=0 for 1 cycle during WAIT_B -> no B pulse; the next strobe after release yields A at +2 and B at +2+DEF_HALF.
